// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: groups the M-stage request/response signals and the
// synchronous-RAM port of mem_access_unit.
// The slave modport is the responder's view. The master modport is the
// pipeline/RAM side that drives requests and RAM read data.
interface mem_access_unit_if #(
    parameter int LANES = 4
);
    logic                  memwriteM;
    logic                  memtoregM;
    logic                  vectorM;
    logic [31:0]           addrM;
    logic [31:0]           wdataM;
    logic [32*LANES-1:0]   vwdataM;
    logic                  stallM;
    logic [31:0]           rdataW;
    logic [32*LANES-1:0]   vrdataW;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [31:0]           mem_rdata;

    modport slave (
        input  memwriteM, memtoregM, vectorM, addrM, wdataM, vwdataM, mem_rdata,
        output stallM, rdataW, vrdataW, mem_addr, mem_wdata, mem_we, mem_re
    );

    modport master (
        output memwriteM, memtoregM, vectorM, addrM, wdataM, vwdataM, mem_rdata,
        input  stallM, rdataW, vrdataW, mem_addr, mem_wdata, mem_we, mem_re
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage memory responder.
// - Scalar accesses complete in a single cycle.
// - Vector accesses of LANES words are serialized over one 32-bit RAM port.
// - stallM is held while a vector transfer is still in progress.
// Optional feature: define MEM_ACCESS_PERF_EN to add saturating
// perf_stall_cnt / perf_vec_cnt outputs.
module mem_access_unit #(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset,      // asynchronous, active low
    mem_access_unit_if.slave       bus
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_vec_cnt
`endif
);
    localparam int LW = $clog2(LANES);

    typedef enum logic {IDLE, VEC} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [31:0]     vbuf_q [LANES-1];
    logic            cap_q;
    logic [LW-1:0]   cap_lane_q;

    logic            req_vec, req_st, req_ld;
    logic            last_beat;
    logic [31:0]     base_addr, beat_addr;
    logic [31:0]     vw_lane [LANES];

    logic            stall, we, re, vec_rd, vec_done;
    logic [31:0]     addr, wdata;

    // Address bits [1:0] are deliberately ignored (word-aligned RAM).
    logic            unused_addr_bits;
    assign unused_addr_bits = ^bus.addrM[1:0];

    // A store wins over a load if both are requested.
    assign req_st    = bus.memwriteM;
    assign req_ld    = bus.memtoregM & ~bus.memwriteM;
    assign req_vec   = bus.vectorM & (bus.memwriteM | bus.memtoregM);
    assign last_beat = (lane_q == LW'(LANES - 1));
    assign base_addr = {bus.addrM[31:2], 2'b00};
    assign beat_addr = base_addr + {{(30 - LW){1'b0}}, lane_q, 2'b00};

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_vw_lane
            assign vw_lane[gi] = bus.vwdataM[32*gi +: 32];
        end
        for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_vr_lane
            assign bus.vrdataW[32*gi +: 32] = vbuf_q[gi];
        end
    endgenerate

    // The last lane is taken straight from the RAM in the W cycle.
    assign bus.vrdataW[32*(LANES-1) +: 32] = bus.mem_rdata;
    assign bus.rdataW = bus.mem_rdata;

    // Next-state logic and RAM/stall outputs.
    // All outputs are forced to zero while reset is asserted.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        stall    = 1'b0;
        we       = 1'b0;
        re       = 1'b0;
        vec_rd   = 1'b0;
        vec_done = 1'b0;
        addr     = 32'd0;
        wdata    = 32'd0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (req_vec) begin
                        // Beat 0 is issued immediately; lane_q is 0 in IDLE.
                        addr = beat_addr;
                        if (bus.memwriteM) begin
                            we    = 1'b1;
                            wdata = vw_lane[lane_q];
                        end else begin
                            re     = 1'b1;
                            vec_rd = 1'b1;
                        end
                        stall   = 1'b1;
                        state_d = VEC;
                        lane_d  = LW'(1);
                    end else if (req_st) begin
                        we    = 1'b1;
                        addr  = base_addr;
                        wdata = bus.wdataM;
                    end else if (req_ld) begin
                        re   = 1'b1;
                        addr = base_addr;
                    end
                end
                VEC: begin
                    addr = beat_addr;
                    if (bus.memwriteM) begin
                        we    = 1'b1;
                        wdata = vw_lane[lane_q];
                    end else if (bus.memtoregM) begin
                        re     = 1'b1;
                        vec_rd = 1'b1;
                    end
                    if (last_beat) begin
                        state_d  = IDLE;
                        lane_d   = '0;
                        vec_done = 1'b1;
                    end else begin
                        stall  = 1'b1;
                        lane_d = lane_q + LW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.stallM    = stall;
    assign bus.mem_we    = we;
    assign bus.mem_re    = re;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;

    // State and lane-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    // Capture returned vector-load words for every lane except the last.
    // Read data arrives one cycle after the beat that requested it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_q      <= 1'b0;
            cap_lane_q <= '0;
            for (int i = 0; i < LANES - 1; i++) begin
                vbuf_q[i] <= 32'd0;
            end
        end else begin
            cap_q      <= vec_rd & ~last_beat;
            cap_lane_q <= lane_q;
            if (cap_q) begin
                vbuf_q[cap_lane_q] <= bus.mem_rdata;
            end
        end
    end

`ifdef MEM_ACCESS_PERF_EN
    // Saturating counts of stall cycles and completed vector accesses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= 32'd0;
            perf_vec_cnt   <= 32'd0;
        end else begin
            if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (vec_done && (perf_vec_cnt != 32'hFFFF_FFFF)) begin
                perf_vec_cnt <= perf_vec_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized checks of mem_access_unit.
// - A word-array RAM model answers the DUT's RAM port.
// - A separate reference memory records what each transaction should
//   have written, and load expectations are drawn from it.
module tb_mem_access_unit;
    localparam int LANES = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] ram     [1024];
    logic [31:0] ref_mem [1024];

    mem_access_unit_if #(.LANES(LANES)) bus ();

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_vec_cnt;
`endif

    mem_access_unit #(.LANES(LANES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MEM_ACCESS_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_vec_cnt   (perf_vec_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: write on mem_we, read data one cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[11:2]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr[11:2]];
    end

    task automatic idle_inputs();
        bus.memwriteM = 1'b0;
        bus.memtoregM = 1'b0;
        bus.vectorM   = 1'b0;
        bus.addrM     = $urandom;
        bus.wdataM    = $urandom;
        for (int i = 0; i < LANES; i++) bus.vwdataM[32*i +: 32] = $urandom;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.memwriteM = 1'b1;
        bus.memtoregM = 1'b0;
        bus.vectorM   = 1'b1;
        bus.addrM     = 32'h0000_0200;
        bus.vwdataM   = '1;
        bus.wdataM    = 32'hFFFF_FFFF;
        #2;
        checks++;
        if ({bus.stallM, bus.mem_we, bus.mem_re} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: stall/we/re=%b expected 000",
                     {bus.stallM, bus.mem_we, bus.mem_re});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 64'd0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h expected 0/0",
                     bus.mem_addr, bus.mem_wdata);
        end
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_scalar_store(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ea;
        ea            = {a[31:2], 2'b00};
        bus.memwriteM = 1'b1;
        bus.memtoregM = 1'b0;
        bus.vectorM   = 1'b0;
        bus.addrM     = a;
        bus.wdataM    = d;
        @(negedge clk);
        checks++;
        if ({bus.mem_we, bus.mem_re, bus.stallM} !== 3'b100 || bus.mem_addr !== ea || bus.mem_wdata !== d) begin
            errors++;
            $display("FAIL scalar_store: we/re/stall=%b addr=%h wdata=%h expected 100 %h %h",
                     {bus.mem_we, bus.mem_re, bus.stallM}, bus.mem_addr, bus.mem_wdata, ea, d);
        end
        ref_mem[ea[11:2]] = d;
        $display("scalar store addr=%h data=%h", a, d);
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_both_high(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ea;
        ea            = {a[31:2], 2'b00};
        bus.memwriteM = 1'b1;
        bus.memtoregM = 1'b1;
        bus.vectorM   = 1'b0;
        bus.addrM     = a;
        bus.wdataM    = d;
        @(negedge clk);
        checks++;
        if ({bus.mem_we, bus.mem_re} !== 2'b10 || bus.mem_wdata !== d || bus.mem_addr !== ea) begin
            errors++;
            $display("FAIL store_wins: we/re=%b addr=%h wdata=%h expected 10 %h %h",
                     {bus.mem_we, bus.mem_re}, bus.mem_addr, bus.mem_wdata, ea, d);
        end
        ref_mem[ea[11:2]] = d;
        $display("store+load request addr=%h data=%h", a, d);
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_scalar_load(input logic [31:0] a);
        logic [31:0] ea;
        logic [31:0] exp_d;
        ea            = {a[31:2], 2'b00};
        exp_d         = ref_mem[ea[11:2]];
        bus.memwriteM = 1'b0;
        bus.memtoregM = 1'b1;
        bus.vectorM   = 1'b0;
        bus.addrM     = a;
        @(negedge clk);
        checks++;
        if ({bus.mem_we, bus.mem_re, bus.stallM} !== 3'b010 || bus.mem_addr !== ea) begin
            errors++;
            $display("FAIL scalar_load_req: we/re/stall=%b addr=%h expected 010 %h",
                     {bus.mem_we, bus.mem_re, bus.stallM}, bus.mem_addr, ea);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.rdataW !== exp_d) begin
            errors++;
            $display("FAIL scalar_load_data: rdataW=%h expected %h", bus.rdataW, exp_d);
        end
        $display("scalar load addr=%h data=%h", a, bus.rdataW);
        next_cycle();
    endtask

    task automatic test_vector_store(input logic [31:0] a, input logic [32*LANES-1:0] v);
        logic [31:0] ea;
        logic        exp_stall;
        bus.memwriteM = 1'b1;
        bus.memtoregM = 1'b0;
        bus.vectorM   = 1'b1;
        bus.addrM     = a;
        bus.vwdataM   = v;
        for (int i = 0; i < LANES; i++) begin
            ea        = {a[31:2], 2'b00} + 32'(4 * i);
            exp_stall = (i != LANES - 1);
            @(negedge clk);
            checks++;
            if ({bus.mem_we, bus.mem_re, bus.stallM} !== {2'b10, exp_stall} ||
                bus.mem_addr !== ea || bus.mem_wdata !== v[32*i +: 32]) begin
                errors++;
                $display("FAIL vec_store_beat%0d: we/re/stall=%b addr=%h wdata=%h expected %b %h %h",
                         i, {bus.mem_we, bus.mem_re, bus.stallM}, bus.mem_addr, bus.mem_wdata,
                         {2'b10, exp_stall}, ea, v[32*i +: 32]);
            end
            ref_mem[ea[11:2]] = v[32*i +: 32];
            next_cycle();
        end
        idle_inputs();
        $display("vector store addr=%h data=%h", a, v);
    endtask

    task automatic test_vector_load(input logic [31:0] a);
        logic [31:0]         ea;
        logic                exp_stall;
        logic [32*LANES-1:0] exp_v;
        for (int i = 0; i < LANES; i++) begin
            ea = {a[31:2], 2'b00} + 32'(4 * i);
            exp_v[32*i +: 32] = ref_mem[ea[11:2]];
        end
        bus.memwriteM = 1'b0;
        bus.memtoregM = 1'b1;
        bus.vectorM   = 1'b1;
        bus.addrM     = a;
        for (int i = 0; i < LANES; i++) begin
            ea        = {a[31:2], 2'b00} + 32'(4 * i);
            exp_stall = (i != LANES - 1);
            @(negedge clk);
            checks++;
            if ({bus.mem_we, bus.mem_re, bus.stallM} !== {2'b01, exp_stall} || bus.mem_addr !== ea) begin
                errors++;
                $display("FAIL vec_load_beat%0d: we/re/stall=%b addr=%h expected %b %h",
                         i, {bus.mem_we, bus.mem_re, bus.stallM}, bus.mem_addr,
                         {2'b01, exp_stall}, ea);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.vrdataW !== exp_v) begin
            errors++;
            $display("FAIL vec_load_data: vrdataW=%h expected %h", bus.vrdataW, exp_v);
        end
        $display("vector load addr=%h data=%h", a, bus.vrdataW);
        next_cycle();
    endtask

    task automatic test_reset_mid_vector(input logic [31:0] a, input logic [32*LANES-1:0] v);
        logic [31:0] ea;
        bus.memwriteM = 1'b1;
        bus.memtoregM = 1'b0;
        bus.vectorM   = 1'b1;
        bus.addrM     = a;
        bus.vwdataM   = v;
        for (int i = 0; i < 2; i++) begin
            ea = {a[31:2], 2'b00} + 32'(4 * i);
            ref_mem[ea[11:2]] = v[32*i +: 32];
            next_cycle();
        end
        // Now in beat 2: the DUT should be stalling and writing.
        checks++;
        if ({bus.stallM, bus.mem_we} !== 2'b11) begin
            errors++;
            $display("FAIL mid_vec_beat2: stall/we=%b expected 11", {bus.stallM, bus.mem_we});
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.stallM, bus.mem_we, bus.mem_re} !== 3'b000 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL mid_vec_reset: stall/we/re=%b addr=%h wdata=%h expected 000 0 0",
                     {bus.stallM, bus.mem_we, bus.mem_re}, bus.mem_addr, bus.mem_wdata);
        end
        $display("reset during vector store addr=%h", a);
        next_cycle();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
    endtask

`ifdef MEM_ACCESS_PERF_EN
    task automatic test_perf();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        test_vector_store(32'h0000_0300, {LANES{$urandom}});
        test_vector_load(32'h0000_0300);
        checks++;
        if (perf_vec_cnt !== 32'd2 || perf_stall_cnt !== 32'd6) begin
            errors++;
            $display("FAIL perf: vec=%0d stall=%0d expected 2 6", perf_vec_cnt, perf_stall_cnt);
        end
        $display("perf vec=%0d stall=%0d", perf_vec_cnt, perf_stall_cnt);
    endtask
`endif

    task automatic test_random(input int n);
        logic [32*LANES-1:0] v;
        logic [31:0]         a;
        for (int k = 0; k < n; k++) begin
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 4095));
            for (int i = 0; i < LANES; i++) v[32*i +: 32] = $urandom;
            case ($urandom_range(0, 4))
                0: test_scalar_store(a, $urandom);
                1: test_scalar_load(a);
                2: test_vector_store(a, v);
                3: test_vector_load(a);
                default: test_both_high(a, $urandom);
            endcase
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        bus.mem_rdata = 32'd0;
        test_reset();
        next_cycle();
        test_scalar_store(32'h0000_0103, 32'hDEAD_BEEF);
        test_scalar_load(32'h0000_0103);
        test_scalar_store(32'h0000_0040, 32'h1234_5678);
        test_scalar_load(32'h0000_0040);
        test_vector_store(32'h0000_0200, {32'h44, 32'h33, 32'h22, 32'h11});
        test_vector_load(32'h0000_0200);
        test_vector_load(32'hFFFF_FFF8);
        test_both_high(32'h0000_0020, 32'hCAFE_F00D);
        test_scalar_load(32'h0000_0020);
        // Back-to-back vector requests with no idle cycle between them.
        test_vector_store(32'h0000_0400, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        test_vector_load(32'h0000_0400);
        test_reset_mid_vector(32'h0000_0500, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        test_scalar_load(32'h0000_0508);
        test_scalar_load(32'h0000_0500);
        test_random(40);
`ifdef MEM_ACCESS_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
